jk_bank_sequencer: RTL and testbench

- Controller for a bank of N JK flip-flop cells. Two requesters share the bank by issuing hold, set, reset and toggle commands to single cells.
- Commands pass through a round-robin arbiter with valid/ready handshakes.
- A sweep mode toggles every cell in index order. It serves as the bank-level exerciser for the JK cell and as its sequencing front end.

---
 rtl/jk_pkg.sv | 11 +
 rtl/jk_cell.sv | 14 +
 rtl/jk_bank_sequencer.sv | 84 ++++++++
 tb/tb_jk_bank_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: command encodings, sequencer states and command-to-J/K mapping
package jk_pkg;
    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_RST  = 2'b01;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_TGL  = 2'b11;
    typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_e;
    function automatic logic [1:0] cmd_jk(input logic [1:0] cmd);
        return {cmd == CMD_SET || cmd == CMD_TGL, cmd == CMD_RST || cmd == CMD_TGL};
    endfunction
endpackage

// File: rtl/jk_cell.sv
// jk_cell: behavioural JK flip-flop with synchronous active-high reset
module jk_cell (
    input  logic clk1,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qinv
);
    always_ff @(posedge clk1)
        if (rst) q <= 1'b0;
        else q <= j ? (k ? ~q : 1'b1) : (k ? 1'b0 : q);
    assign qinv = ~q;
endmodule

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: round-robin command front end and toggle sweeper for a bank of JK cells
module jk_bank_sequencer
    import jk_pkg::*;
#(
    parameter int N   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk1,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [1:0]     req0_cmd,
    input  logic [IDW-1:0] req0_idx,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [1:0]     req1_cmd,
    input  logic [IDW-1:0] req1_idx,
    output logic           req1_ready,
    input  logic           sweep_start,
    output logic           busy,
    output logic           done,
    output logic           grant_id,
    output logic [N-1:0]   q,
    output logic [N-1:0]   qinv
);
    state_e         state;
    logic           rr;
    logic [IDW-1:0] cnt;
    logic           pv;
    logic [1:0]     pcmd;
    logic [IDW-1:0] pidx;
    logic           open;
    logic           hs;
    // sweep_start wins the cycle it is seen, so no command can slip in alongside it
    assign open       = !rst && state == IDLE && !sweep_start;
    assign req0_ready = open && req0_valid && (!req1_valid || !rr);
    assign req1_ready = open && req1_valid && (!req0_valid || rr);
    assign hs         = req0_ready || req1_ready;
    assign busy       = state != IDLE || pv;
    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= 1'b0;
            cnt      <= '0;
            pv       <= 1'b0;
            pcmd     <= CMD_HOLD;
            pidx     <= '0;
            grant_id <= 1'b0;
            done     <= 1'b0;
        end else begin
            pv   <= hs;
            done <= state == SWEEP && cnt == IDW'(N - 1);
            if (hs) begin
                {pcmd, pidx} <= req1_ready ? {req1_cmd, req1_idx} : {req0_cmd, req0_idx};
                grant_id     <= req1_ready;
            end
            if (hs && req0_valid && req1_valid) rr <= ~rr;
            unique case (state)
                IDLE: if (sweep_start) begin
                    state <= SWEEP;
                    cnt   <= '0;
                end
                SWEEP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == IDW'(N - 1)) state <= FINISH;
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_cell
        logic [1:0] jk;
        assign jk = (state == SWEEP && cnt == IDW'(g)) ? 2'b11 :
                    (pv && pidx == IDW'(g))            ? cmd_jk(pcmd) : 2'b00;
        jk_cell u_cell (
            .clk1 (clk1),
            .rst  (rst),
            .j    (jk[1]),
            .k    (jk[0]),
            .q    (q[g]),
            .qinv (qinv[g])
        );
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: directed scoreboard bench for the JK bank sequencer
module tb_jk_bank_sequencer;
    import jk_pkg::*;
    logic       clk1 = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, sweep_start;
    logic [1:0] req0_cmd, req1_cmd;
    logic [2:0] req0_idx, req1_idx;
    logic       req0_ready, req1_ready, busy, done, grant_id;
    logic [7:0] q, qinv;
    logic       r6_valid;
    logic [1:0] r6_cmd;
    logic [2:0] r6_idx;
    logic       r6_ready, r6_ready1, busy6, done6, grant6;
    logic [5:0] q6, qinv6;
    typedef enum {K_Q, K_QI, K_GR, K_R0, K_R1, K_DONE, K_BUSY, K_R6, K_Q6} kind_e;
    typedef struct {
        int          due;
        kind_e       kind;
        logic [63:0] want;
    } item_t;
    item_t sb[$];
    int    cyc = 0;
    int    n_run = 0;
    int    n_fail = 0;
    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;
    jk_bank_sequencer #(.N(8)) dut (
        .clk1 (clk1), .rst (rst),
        .req0_valid (req0_valid), .req0_cmd (req0_cmd), .req0_idx (req0_idx), .req0_ready (req0_ready),
        .req1_valid (req1_valid), .req1_cmd (req1_cmd), .req1_idx (req1_idx), .req1_ready (req1_ready),
        .sweep_start (sweep_start), .busy (busy), .done (done), .grant_id (grant_id),
        .q (q), .qinv (qinv)
    );
    jk_bank_sequencer #(.N(6)) dut6 (
        .clk1 (clk1), .rst (rst),
        .req0_valid (r6_valid), .req0_cmd (r6_cmd), .req0_idx (r6_idx), .req0_ready (r6_ready),
        .req1_valid (1'b0), .req1_cmd (2'b00), .req1_idx (3'd0), .req1_ready (r6_ready1),
        .sweep_start (1'b0), .busy (busy6), .done (done6), .grant_id (grant6),
        .q (q6), .qinv (qinv6)
    );
    task automatic chk(input kind_e kind, input logic [63:0] want, input int d);
        item_t it;
        it.due  = cyc + d;
        it.kind = kind;
        it.want = want;
        sb.push_back(it);
    endtask
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask
    always @(negedge clk1) begin
        logic [63:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].kind)
                    K_Q:     act = 64'(q);
                    K_QI:    act = 64'(qinv);
                    K_GR:    act = 64'(grant_id);
                    K_R0:    act = 64'(req0_ready);
                    K_R1:    act = 64'(req1_ready);
                    K_DONE:  act = 64'(done);
                    K_BUSY:  act = 64'(busy);
                    K_R6:    act = 64'(r6_ready);
                    default: act = 64'(q6);
                endcase
                n_run++;
                if (act !== sb[i].want) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h", sb[i].kind.name(), cyc, act, sb[i].want);
                end
                sb.delete(i);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "timeout");
    end
    initial begin
        logic [7:0] cont_q[4];
        cont_q = '{8'h09, 8'h0B, 8'h0A, 8'h08};
        rst = 1'b1;
        {req0_valid, req1_valid, sweep_start, r6_valid} = '0;
        {req0_cmd, req1_cmd, r6_cmd} = '0;
        {req0_idx, req1_idx, r6_idx} = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            req0_valid  = 1'($urandom_range(0, 1));
            req1_valid  = 1'($urandom_range(0, 1));
            sweep_start = 1'($urandom_range(0, 1));
            req0_cmd    = 2'($urandom);
            req1_cmd    = 2'($urandom);
            req0_idx    = 3'($urandom);
            req1_idx    = 3'($urandom);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        chk(K_R0, 0, 0); chk(K_R1, 0, 0);
        chk(K_Q, 8'h00, 0); chk(K_QI, 8'hFF, 0); chk(K_BUSY, 0, 0); chk(K_DONE, 0, 0);
        tick();
        rst = 1'b0;
        {req0_valid, req1_valid, sweep_start} = '0;
        chk(K_GR, 0, 0); chk(K_BUSY, 0, 0);
        tick();
        req0_valid = 1'b1; req0_cmd = CMD_SET; req0_idx = 3'd3;
        chk(K_R0, 1, 0); chk(K_R1, 0, 0);
        chk(K_Q, 8'h00, 1); chk(K_GR, 0, 1); chk(K_BUSY, 1, 1);
        chk(K_Q, 8'h08, 2); chk(K_QI, 8'hF7, 2);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_cmd = CMD_TGL; req0_idx = 3'd0;
            req1_valid = 1'b1; req1_cmd = CMD_TGL; req1_idx = 3'd1;
            chk(K_R0, (i % 2 == 0), 0); chk(K_R1, (i % 2 == 1), 0);
            chk(K_GR, i % 2, 1); chk(K_Q, cont_q[i], 2);
            tick();
        end
        {req0_valid, req1_valid} = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1'b1; req1_cmd = CMD_SET; req1_idx = 3'(i);
            chk(K_R1, 1, 0); chk(K_GR, 1, 1);
            tick();
        end
        req1_valid = 1'b1; req1_cmd = CMD_SET; req1_idx = 3'd5; sweep_start = 1'b1;
        chk(K_R0, 0, 0); chk(K_R1, 0, 0); chk(K_BUSY, 1, 0); chk(K_Q, 8'h0F, 1);
        tick();
        req0_valid = 1'b1; req0_cmd = CMD_TGL; req0_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            sweep_start = (k == 2);
            chk(K_R0, 0, 0); chk(K_R1, 0, 0); chk(K_DONE, 0, 0); chk(K_BUSY, 1, 0);
            chk(K_Q, 8'h0F ^ 8'((1 << k) - 1), 0);
            tick();
        end
        {req0_valid, req1_valid, sweep_start} = '0;
        chk(K_DONE, 1, 0); chk(K_BUSY, 1, 0); chk(K_Q, 8'hF0, 0);
        tick();
        chk(K_DONE, 0, 0); chk(K_BUSY, 0, 0); chk(K_Q, 8'hF0, 0);
        tick();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        repeat (4) tick();
        chk(K_Q, 8'hFF, 0); chk(K_BUSY, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk(K_Q, 8'h00, 0); chk(K_QI, 8'hFF, 0); chk(K_BUSY, 0, 0); chk(K_DONE, 0, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            req0_valid = (i == 0); req0_cmd = CMD_SET; req0_idx = 3'd2;
            if (i == 0) chk(K_R0, 1, 0);
            chk(K_DONE, 0, 0); chk(K_BUSY, (i == 1), 0);
            if (i == 2) chk(K_Q, 8'h04, 0);
            tick();
        end
        req0_valid = 1'b0;
        r6_valid = 1'b1; r6_cmd = CMD_SET; r6_idx = 3'd7;
        chk(K_R6, 1, 0); chk(K_Q6, 6'h00, 2);
        tick();
        r6_idx = 3'd5;
        chk(K_R6, 1, 0); chk(K_Q6, 6'h20, 2);
        tick();
        r6_valid = 1'b0;
        repeat (4) tick();
        if (sb.size() != 0) begin
            n_fail += sb.size();
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
